marc_main_memory: RTL and testbench
===================================

# marc_main_memory

Main-memory stage directly downstream of the mARC `Processor` core. It consumes the core's address on `busA`, its store data on `busB` and its `rw` strobe, and returns instruction/data words on `dataIn`. It also sequences the boot word that loads the PC after reset, and decodes one memory-mapped output register used to observe program results.

## Interface
- `ADDR_W`, 15: word-address width. The array holds 2^ADDR_W 16-bit words, byte address = word address × 2.
- `BOOT_WORD`, 16'h8200: word driven during boot (`call 1024`).
- `BOOT_CYCLES`, 5: clock cycles `BOOT_WORD` is held after reset release (1..255).
- `IO_ADDR`, 16'h0800: byte address of the output register. It overrides the array at that address.
- `clk`  in  1: clock. All state updates on the rising edge.
- `reset`  in  1: reset, asynchronous, active-low (0 = reset asserted).
- `busA`  in  16: byte address from the core.
- `busB`  in  16: store data from the core.
- `rw`  in  1: 1 = write `busB` at `busA` this cycle, 0 = read.
- `dataIn`  out  16: read data / instruction word to the core.
- `out_data`  out  16: last word stored to `IO_ADDR`.
- `out_valid`  out  1: one-cycle pulse on each store to `IO_ADDR`.
- `out_count`  out  8: number of stores to `IO_ADDR`, wraps 255→0.
- `align_err`  out  1: sticky; set by any access with `busA[0]`=1.
- `booting`  out  1: 1 while in state BOOT.

## Operation
- FSM states: BOOT, RUN.
  - `reset`=0 forces BOOT asynchronously and loads the boot counter with `BOOT_CYCLES`.
  - In BOOT, the counter decrements each edge after release. At the edge where it reaches 0, the FSM enters RUN. RUN is terminal until the next reset.
- BOOT behaviour:
  - `dataIn` = `BOOT_WORD` combinationally, including while `reset`=0.
  - Writes are ignored.
  - `align_err` is not updated.
- RUN read:
  - On each edge with `rw`=0, `dataIn` registers the word at `busA[ADDR_W:1]`.
  - If `busA` = `IO_ADDR`, it registers `out_data` instead.
  - If `busA[15:ADDR_W+1]` ≠ 0 (only possible when `ADDR_W` < 15), it registers 16'h0000.
- RUN write:
  - On an edge with `rw`=1 and `busA` = `IO_ADDR`: `out_data` ← `busB`, `out_valid` ← 1 for one cycle, `out_count` += 1. The array is not written.
  - Otherwise, if the address is in range, the array word ← `busB`. Out-of-range writes are dropped.
  - `dataIn` holds its previous value on write cycles.
- Alignment: the word index ignores `busA[0]`. Any RUN access with `busA[0]`=1 sets `align_err`, which stays set until reset. The access is still performed on the even word.
- Array contents are not reset, which allows program preload and survives reset. `out_data`, `out_valid`, `out_count` and `align_err` reset to 0.

## Timing
- Reset values:
  - `dataIn` = `BOOT_WORD`, `booting` = 1.
  - `out_data` = 0, `out_valid` = 0, `out_count` = 0, `align_err` = 0.
- Read latency: 1 cycle. `dataIn` is valid after the edge that samples `busA`.
- Read of a word written on the same edge returns the old value (read-before-write). A read on the following cycle returns the new value.
- The first RUN read sample occurs on the edge after the counter reaches 0. `dataIn` keeps `BOOT_WORD` until that edge.
- `out_valid` is high exactly during the cycle following the store edge. Back-to-back stores to `IO_ADDR` keep it high and increment `out_count` every cycle.
- Reset asserted mid-RUN:
  - `dataIn` switches to `BOOT_WORD` and the output registers clear immediately.
  - Any write on a concurrent edge is lost.
  - The array keeps all completed writes.

## Test plan
- Boot: assert `reset`=0 for 1 cycle, release. Expect `dataIn`=16'h8200 and `booting`=1 for 5 edges, then `booting`=0.
- Read/write: in RUN, write 16'h5140 at 16'h0400, then read 16'h0400. Expect `dataIn`=16'h5140 one cycle after the read edge. A same-edge read returns the prior content.
- Output register: store 16'h0140 to 16'h0800. Expect `out_data`=16'h0140, a one-cycle `out_valid` pulse and `out_count`=1. Array word 1024 is unchanged, and a read of 16'h0800 returns 16'h0140.
- High address / wrap: write 16'hABCD at 16'hF004 and read it back as 16'hABCD. Perform 256 IO stores; expect `out_count` to wrap to 0.
- Alignment: read 16'h0401. Expect `dataIn` = word at 16'h0400 and `align_err`=1, which stays 1 through later aligned accesses until reset.
- Reset mid-run: pulse `reset` low between writes. Expect `dataIn`=16'h8200 and cleared output registers, while the earlier write at 16'h0400 still reads back in RUN.

Source files
------------

// File: rtl/marc_main_memory.sv
// marc_main_memory: main-memory stage downstream of the mARC Processor core.
// Serves instruction/data reads with one cycle of latency, accepts stores,
// sequences the post-reset boot word that loads the PC, and decodes one
// memory-mapped output register used to observe program results.
module marc_main_memory #(
    parameter int unsigned ADDR_W      = 15,
    parameter logic [15:0] BOOT_WORD   = 16'h8200,
    parameter int unsigned BOOT_CYCLES = 5,
    parameter logic [15:0] IO_ADDR     = 16'h0800
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] busA,
    input  logic [15:0] busB,
    input  logic        rw,
    output logic [15:0] dataIn,
    output logic [15:0] out_data,
    output logic        out_valid,
    output logic [7:0]  out_count,
    output logic        align_err,
    output logic        booting
);

    localparam int unsigned DEPTH     = 1 << ADDR_W;
    localparam logic [7:0]  BOOT_INIT = 8'(BOOT_CYCLES);

    typedef enum logic {
        ST_BOOT,
        ST_RUN
    } state_e;

    state_e            state_q, state_d;
    logic [7:0]        boot_cnt_q, boot_cnt_d;
    logic [15:0]       data_q, data_d;
    logic [15:0]       out_data_q, out_data_d;
    logic              out_valid_q, out_valid_d;
    logic [7:0]        out_count_q, out_count_d;
    logic              align_err_q, align_err_d;

    // Word array; deliberately not reset so preloaded programs survive reset.
    logic [15:0]       mem_q [DEPTH];

    logic [ADDR_W-1:0] word_idx;
    logic              is_io;
    logic              in_range;
    logic              mem_we;

    // Address decode: the even word is always addressed, bit 0 only flags misalignment.
    always_comb begin
        word_idx = busA[ADDR_W:1];
        is_io    = ({busA[15:1], 1'b0} == IO_ADDR);
        in_range = ((busA >> (ADDR_W + 1)) == 16'h0000);
        mem_we   = (state_q == ST_RUN) && rw && !is_io && in_range;
    end

    // Next-state logic for the boot sequencer, read path and output register.
    always_comb begin
        state_d     = state_q;
        boot_cnt_d  = boot_cnt_q;
        data_d      = data_q;
        out_data_d  = out_data_q;
        out_valid_d = 1'b0;
        out_count_d = out_count_q;
        align_err_d = align_err_q;

        case (state_q)
            ST_BOOT: begin
                // data_q still holds BOOT_WORD from reset, so no read path here.
                boot_cnt_d = boot_cnt_q - 8'd1;
                if (boot_cnt_q == 8'd1) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (busA[0]) begin
                    align_err_d = 1'b1;
                end
                if (rw) begin
                    if (is_io) begin
                        out_data_d  = busB;
                        out_valid_d = 1'b1;
                        out_count_d = out_count_q + 8'd1;
                    end
                end else begin
                    if (is_io) begin
                        data_d = out_data_q;
                    end else if (!in_range) begin
                        data_d = 16'h0000;
                    end else begin
                        data_d = mem_q[word_idx];
                    end
                end
            end
            default: begin
                state_d = ST_BOOT;
            end
        endcase
    end

    // Control and output registers; reset returns to BOOT with the boot word on the bus.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_BOOT;
            boot_cnt_q  <= BOOT_INIT;
            data_q      <= BOOT_WORD;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_count_q <= '0;
            align_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            boot_cnt_q  <= boot_cnt_d;
            data_q      <= data_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            out_count_q <= out_count_d;
            align_err_q <= align_err_d;
        end
    end

    // Array write port; the read above sees the pre-edge contents (read-before-write).
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[word_idx] <= busB;
        end
    end

    assign dataIn    = data_q;
    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign out_count = out_count_q;
    assign align_err = align_err_q;
    assign booting   = (state_q == ST_BOOT);

endmodule

// File: tb/tb_marc_main_memory.sv
// Self-checking bench for marc_main_memory: directed boot/IO/alignment/reset
// scenarios plus randomized traffic against a behavioural memory model.
module tb_marc_main_memory;

    localparam int unsigned BOOT_N = 5;
    localparam logic [15:0] BOOT_W = 16'h8200;
    localparam logic [15:0] IO_A   = 16'h0800;

    logic        clk;
    logic        reset;
    logic [15:0] busA;
    logic [15:0] busB;
    logic        rw;
    logic [15:0] dataIn;
    logic [15:0] out_data;
    logic        out_valid;
    logic [7:0]  out_count;
    logic        align_err;
    logic        booting;

    marc_main_memory #(
        .ADDR_W      (15),
        .BOOT_WORD   (BOOT_W),
        .BOOT_CYCLES (BOOT_N),
        .IO_ADDR     (IO_A)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .busA      (busA),
        .busB      (busB),
        .rw        (rw),
        .dataIn    (dataIn),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_count (out_count),
        .align_err (align_err),
        .booting   (booting)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference model state
    logic [15:0] ref_mem [int unsigned];
    logic [15:0] m_data;
    logic [15:0] m_out;
    logic        m_valid;
    int unsigned m_cnt;
    logic        m_align;
    int unsigned edges;
    logic [15:0] pool [16];

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".dataIn"},    dataIn,            m_data);
        chk({tag, ".out_data"},  out_data,          m_out);
        chk({tag, ".out_valid"}, 16'(out_valid),    16'(m_valid));
        chk({tag, ".out_count"}, 16'(out_count),    16'(m_cnt % 256));
        chk({tag, ".align_err"}, 16'(align_err),    16'(m_align));
        chk({tag, ".booting"},   16'(booting),      16'(edges < BOOT_N));
    endtask

    task automatic model_reset();
        m_data  = BOOT_W;
        m_out   = '0;
        m_valid = 1'b0;
        m_cnt   = 0;
        m_align = 1'b0;
        edges   = 0;
    endtask

    // One bus cycle: drive, clock, update the model from the rules, compare.
    task automatic step(input string tag, input logic w, input logic [15:0] a, input logic [15:0] d);
        int unsigned key;
        rw   = w;
        busA = a;
        busB = d;
        @(posedge clk);
        if (edges >= BOOT_N) begin
            key     = int'(a) / 2;
            m_valid = 1'b0;
            if (a % 2 == 1) m_align = 1'b1;
            if (w) begin
                if (key * 2 == int'(IO_A)) begin
                    m_out   = d;
                    m_valid = 1'b1;
                    m_cnt   = m_cnt + 1;
                end else begin
                    ref_mem[key] = d;
                end
            end else begin
                if (key * 2 == int'(IO_A)) m_data = m_out;
                else                       m_data = ref_mem[key];
            end
        end
        edges++;
        #1;
        check_all(tag);
    endtask

    initial begin
        reset = 1'b1;
        rw    = 1'b0;
        busA  = '0;
        busB  = '0;
        model_reset();

        // Power-on reset for one cycle
        #1 reset = 1'b0;
        #2 check_all("reset");
        @(posedge clk);
        #2 check_all("reset_hold");
        reset = 1'b1;

        // Boot: stores to IO must be ignored while booting
        for (int i = 0; i < BOOT_N; i++) step("boot", 1'b1, IO_A, 16'h1234);

        // Directed read/write and IO register
        step("wr400",     1'b1, 16'h0400, 16'h5140);
        step("rd400",     1'b0, 16'h0400, 16'h0000);
        step("wr400b",    1'b1, 16'h0400, 16'h2222);
        step("rd400b",    1'b0, 16'h0400, 16'h0000);
        step("wr400c",    1'b1, 16'h0400, 16'h5140);
        step("rdio0",     1'b0, IO_A,     16'h0000);
        step("stio",      1'b1, IO_A,     16'h0140);
        step("stio_idle", 1'b0, 16'h0400, 16'h0000);
        step("rdio",      1'b0, IO_A,     16'h0000);
        step("wrF004",    1'b1, 16'hF004, 16'hABCD);
        step("rdF004",    1'b0, 16'hF004, 16'h0000);
        step("rd401",     1'b0, 16'h0401, 16'h0000);
        step("rdF004b",   1'b0, 16'hF004, 16'h0000);

        // Randomized traffic over a preloaded address pool
        pool[0] = 16'h0400;
        pool[1] = 16'hF004;
        for (int i = 2; i < 16; i++) begin
            pool[i] = 16'($urandom) & 16'hFFFE;
            if (pool[i] == IO_A) pool[i] = 16'h0402;
        end
        for (int i = 2; i < 16; i++) step("preload", 1'b1, pool[i], 16'($urandom));
        for (int i = 0; i < 300; i++) begin
            logic [15:0] a;
            int unsigned r;
            r = $urandom_range(0, 9);
            a = pool[$urandom_range(0, 15)];
            if (r == 0)      a = IO_A;
            else if (r == 1) a = a | 16'h0001;
            step("rand", ($urandom_range(0, 2) == 0), a, 16'($urandom));
        end

        // Reset mid-run with a concurrent write that must be lost
        #3;
        reset = 1'b0;
        rw    = 1'b1;
        busA  = 16'h0400;
        busB  = 16'hDEAD;
        model_reset();
        #1 check_all("midreset");
        @(posedge clk);
        #1 check_all("midreset_hold");
        #2 reset = 1'b1;
        for (int i = 0; i < BOOT_N; i++) step("reboot", 1'b0, 16'h0400, 16'h0000);
        step("rd400_after_reset", 1'b0, 16'h0400, 16'h0000);
        step("rdF004_after_reset", 1'b0, 16'hF004, 16'h0000);

        // 256 back-to-back IO stores: counter wraps to 0
        for (int i = 0; i < 256; i++) step("io_burst", 1'b1, IO_A, 16'(i));
        chk("cnt_wrap", 16'(out_count), 16'h0000);
        step("io_burst_end", 1'b0, 16'h0400, 16'h0000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
